// File: rtl/price_sched_if.sv
// ---------------------------------------------------------------------------
// price_sched_if
//   Bundles every non-clock signal of price_sched: the two checkout-lane
//   request channels, the unit_price datapath hookup and the per-lane
//   results.
//
//   Lane channel handshake: an item transfers on a rising clock edge where
//   reqN_valid and reqN_ready are both high. The requester holds valid and
//   its data stable until that edge; it may drop valid earlier, in which
//   case nothing is accepted. ready is combinational and may only rise
//   while the controller is idle.
//
//   Modports:
//     master - lane logic / datapath side (drives requests and dp_result)
//     slave  - price_sched side
// ---------------------------------------------------------------------------
interface price_sched_if;
    // lane 0 request channel
    logic        req0_valid;
    logic [3:0]  req0_price;
    logic [3:0]  req0_num;
    logic        req0_last;
    logic        req0_ready;
    // lane 1 request channel
    logic        req1_valid;
    logic [3:0]  req1_price;
    logic [3:0]  req1_num;
    logic        req1_last;
    logic        req1_ready;
    // datapath hookup
    logic [3:0]  dp_price;
    logic [3:0]  dp_num;
    logic        dp_start;
    logic [7:0]  dp_result;
    // per-lane results and status
    logic [11:0] total0;
    logic [11:0] total1;
    logic        ovf0;
    logic        ovf1;
    logic        done0;
    logic        done1;
    logic        busy;
    logic [1:0]  dbg_state;

    modport master (
        output req0_valid, req0_price, req0_num, req0_last,
        input  req0_ready,
        output req1_valid, req1_price, req1_num, req1_last,
        input  req1_ready,
        input  dp_price, dp_num, dp_start,
        output dp_result,
        input  total0, total1, ovf0, ovf1, done0, done1, busy, dbg_state
    );

    modport slave (
        input  req0_valid, req0_price, req0_num, req0_last,
        output req0_ready,
        input  req1_valid, req1_price, req1_num, req1_last,
        output req1_ready,
        output dp_price, dp_num, dp_start,
        input  dp_result,
        output total0, total1, ovf0, ovf1, done0, done1, busy, dbg_state
    );
endinterface

// File: rtl/price_sched.sv
// ---------------------------------------------------------------------------
// price_sched
//   Shares one fixed-latency unit-price datapath (4b price x 4b num -> 8b)
//   between two checkout lanes. Items are accepted one at a time with
//   round-robin arbitration, issued to the datapath, and their products
//   accumulated into a per-lane 12-bit saturating total. The last item of a
//   lane's transaction produces a one-cycle done pulse together with the
//   final total.
//
//   Parameter:
//     LAT  datapath latency, dp_start cycle to dp_result valid (1..15)
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  price_sched_if.slave:
//            req0_* / req1_*   lane request channels (valid/ready)
//            dp_price, dp_num  operands, held from ISSUE through ACC
//            dp_start          one-cycle issue strobe (registered)
//            dp_result         product, sampled in ACC
//            total0/1, ovf0/1  running totals and sticky saturation flags
//            done0/1           transaction-complete pulses
//            busy              controller not idle
//            dbg_state         current FSM state
//
//   Accept at cycle T -> dp_start at T+1 -> dp_result sampled at T+1+LAT ->
//   total/done visible (and next accept possible) at T+2+LAT.
// ---------------------------------------------------------------------------
module price_sched #(
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    price_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACC   = 2'd3
    } state_t;

    // Number of WAIT cycles between ISSUE and ACC.
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t      r_state;
    logic [3:0]  r_price;
    logic [3:0]  r_num;
    logic        r_last;
    logic        r_lane;      // lane of the item in flight
    logic        r_rr_last;   // lane granted most recently (1 after reset)
    logic [3:0]  r_wait_cnt;
    logic [11:0] r_total0;
    logic [11:0] r_total1;
    logic        r_ovf0;
    logic        r_ovf1;
    logic        r_fresh0;    // next lane-0 accept starts a new transaction
    logic        r_fresh1;    // next lane-1 accept starts a new transaction
    logic        r_done0;
    logic        r_done1;
    logic        r_dp_start;

    logic        w_idle;
    logic        w_sel;
    logic        w_rdy0;
    logic        w_rdy1;
    logic        w_accept;
    logic [11:0] w_cur_total;
    logic [12:0] w_sum;
    logic [11:0] w_sat_total;

    assign w_idle = (r_state == S_IDLE);

    // Lane selection: a lone valid lane wins; on a tie the lane that was
    // not granted last wins.
    always_comb begin
        w_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_sel = ~r_rr_last;
        end else begin
            w_sel = bus.req1_valid;
        end
    end

    assign w_rdy0   = w_idle && bus.req0_valid && !w_sel;
    assign w_rdy1   = w_idle && bus.req1_valid &&  w_sel;
    assign w_accept = w_rdy0 || w_rdy1;

    // 13-bit intermediate so a carry out of 12 bits marks saturation.
    assign w_cur_total = r_lane ? r_total1 : r_total0;
    assign w_sum       = {1'b0, w_cur_total} + {5'd0, bus.dp_result};
    assign w_sat_total = w_sum[12] ? 12'hFFF : w_sum[11:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_price    <= 4'd0;
            r_num      <= 4'd0;
            r_last     <= 1'b0;
            r_lane     <= 1'b0;
            r_rr_last  <= 1'b1;
            r_wait_cnt <= 4'd0;
            r_total0   <= 12'd0;
            r_total1   <= 12'd0;
            r_ovf0     <= 1'b0;
            r_ovf1     <= 1'b0;
            r_fresh0   <= 1'b1;
            r_fresh1   <= 1'b1;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_dp_start <= 1'b0;
        end else begin
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_dp_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_price    <= w_sel ? bus.req1_price : bus.req0_price;
                        r_num      <= w_sel ? bus.req1_num   : bus.req0_num;
                        r_last     <= w_sel ? bus.req1_last  : bus.req0_last;
                        r_lane     <= w_sel;
                        r_rr_last  <= w_sel;
                        r_dp_start <= 1'b1;
                        r_state    <= S_ISSUE;
                        // First item of a new transaction: the old total
                        // and overflow flag are discarded for this lane.
                        if (!w_sel && r_fresh0) begin
                            r_total0 <= 12'd0;
                            r_ovf0   <= 1'b0;
                            r_fresh0 <= 1'b0;
                        end
                        if (w_sel && r_fresh1) begin
                            r_total1 <= 12'd0;
                            r_ovf1   <= 1'b0;
                            r_fresh1 <= 1'b0;
                        end
                    end
                end

                S_ISSUE: begin
                    if (LAT_M1 == 4'd0) begin
                        r_state <= S_ACC;
                    end else begin
                        r_wait_cnt <= LAT_M1;
                        r_state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_state <= S_ACC;
                    end
                end

                S_ACC: begin
                    if (r_lane) begin
                        r_total1 <= w_sat_total;
                        if (w_sum[12]) begin
                            r_ovf1 <= 1'b1;
                        end
                        if (r_last) begin
                            r_done1  <= 1'b1;
                            r_fresh1 <= 1'b1;
                        end
                    end else begin
                        r_total0 <= w_sat_total;
                        if (w_sum[12]) begin
                            r_ovf0 <= 1'b1;
                        end
                        if (r_last) begin
                            r_done0  <= 1'b1;
                            r_fresh0 <= 1'b1;
                        end
                    end
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.dp_price   = r_price;
    assign bus.dp_num     = r_num;
    assign bus.dp_start   = r_dp_start;
    assign bus.total0     = r_total0;
    assign bus.total1     = r_total1;
    assign bus.ovf0       = r_ovf0;
    assign bus.ovf1       = r_ovf1;
    assign bus.done0      = r_done0;
    assign bus.done1      = r_done1;
    assign bus.busy       = !w_idle;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_price_sched.sv
// ---------------------------------------------------------------------------
// tb_price_sched
//   Four price_sched instances with LAT = 1..4, each driven by its own lane
//   drivers and fed by a latency-accurate multiplier model. A transaction
//   level model predicts ready, busy, dp_start, operands, totals, ovf and
//   done for every instance on every cycle; directed scenarios add literal
//   checks on the values worked out by hand.
// ---------------------------------------------------------------------------
module tb_price_sched;

    logic clk;
    logic rst;

    // bench-side request drivers, indexed [instance][lane]
    logic        b_valid [4][2];
    logic [3:0]  b_price [4][2];
    logic [3:0]  b_num   [4][2];
    logic        b_last  [4][2];
    // observed DUT outputs
    logic        o_ready [4][2];
    logic [11:0] o_total [4][2];
    logic        o_ovf   [4][2];
    logic        o_done  [4][2];
    logic        o_busy  [4];
    logic        o_start [4];
    logic [3:0]  o_dpp   [4];
    logic [3:0]  o_dpn   [4];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs and multiplier models ----------------
    for (genvar g = 0; g < 4; g++) begin : g_dut
        price_sched_if bus ();
        logic [3:0] ctr;
        logic [7:0] prod;

        price_sched #(.LAT(g + 1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.req0_valid = b_valid[g][0];
        assign bus.req0_price = b_price[g][0];
        assign bus.req0_num   = b_num[g][0];
        assign bus.req0_last  = b_last[g][0];
        assign bus.req1_valid = b_valid[g][1];
        assign bus.req1_price = b_price[g][1];
        assign bus.req1_num   = b_num[g][1];
        assign bus.req1_last  = b_last[g][1];

        assign o_ready[g][0] = bus.req0_ready;
        assign o_ready[g][1] = bus.req1_ready;
        assign o_total[g][0] = bus.total0;
        assign o_total[g][1] = bus.total1;
        assign o_ovf[g][0]   = bus.ovf0;
        assign o_ovf[g][1]   = bus.ovf1;
        assign o_done[g][0]  = bus.done0;
        assign o_done[g][1]  = bus.done1;
        assign o_busy[g]     = bus.busy;
        assign o_start[g]    = bus.dp_start;
        assign o_dpp[g]      = bus.dp_price;
        assign o_dpn[g]      = bus.dp_num;

        // Product is valid only in the cycle exactly LAT after dp_start;
        // any other cycle shows a junk value.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                ctr  <= 4'd0;
                prod <= 8'd0;
            end else if (bus.dp_start) begin
                ctr  <= 4'(g + 1);
                prod <= {4'd0, bus.dp_price} * {4'd0, bus.dp_num};
            end else if (ctr != 4'd0) begin
                ctr <= ctr - 4'd1;
            end
        end
        assign bus.dp_result = (ctr == 4'd1) ? prod : 8'hA5;
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    int  m_lat   [4];
    bit  m_infl  [4];
    int  m_acc   [4];
    int  m_lane  [4];
    int  m_p     [4];
    int  m_n     [4];
    bit  m_lastf [4];
    int  m_rr    [4];
    int  m_tot   [4][2];
    bit  m_ovf   [4][2];
    bit  m_fresh [4][2];
    int  acc_cnt [4][2];
    int  last_acc[4][2];
    int  done_cyc[4][2];
    int  grant_q [4][$];
    int  acc_q   [4][$];

    bit  er[2];
    bit  ed[2];
    int  ml;
    int  msum;

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_lat[k] = k + 1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst) begin
                m_infl[k] = 1'b0;
                m_rr[k]   = 1;
                for (int l = 0; l < 2; l++) begin
                    m_tot[k][l]   = 0;
                    m_ovf[k][l]   = 1'b0;
                    m_fresh[k][l] = 1'b1;
                    chk("rst_total", k, o_total[k][l], 0);
                    chk("rst_ovf", k, o_ovf[k][l], 0);
                    chk("rst_done", k, o_done[k][l], 0);
                end
                chk("rst_busy", k, o_busy[k], 0);
                chk("rst_dp_start", k, o_start[k], 0);
            end else begin
                ed[0] = 1'b0;
                ed[1] = 1'b0;
                // item completion becomes visible LAT+2 cycles after accept
                if (m_infl[k] && cyc == m_acc[k] + m_lat[k] + 2) begin
                    ml   = m_lane[k];
                    msum = m_tot[k][ml] + m_p[k] * m_n[k];
                    if (msum > 4095) begin
                        m_tot[k][ml] = 4095;
                        m_ovf[k][ml] = 1'b1;
                    end else begin
                        m_tot[k][ml] = msum;
                    end
                    if (m_lastf[k]) begin
                        ed[ml]         = 1'b1;
                        m_fresh[k][ml] = 1'b1;
                    end
                    m_infl[k] = 1'b0;
                end

                er[0] = 1'b0;
                er[1] = 1'b0;
                if (!m_infl[k]) begin
                    if (b_valid[k][0] && b_valid[k][1]) begin
                        er[0] = (m_rr[k] == 1);
                        er[1] = (m_rr[k] == 0);
                    end else begin
                        er[0] = b_valid[k][0];
                        er[1] = b_valid[k][1];
                    end
                end

                chk("ready0", k, o_ready[k][0], er[0]);
                chk("ready1", k, o_ready[k][1], er[1]);
                chk("ready_excl", k, o_ready[k][0] & o_ready[k][1], 0);
                chk("busy", k, o_busy[k], m_infl[k]);
                chk("dp_start", k, o_start[k], m_infl[k] && cyc == m_acc[k] + 1);
                if (m_infl[k] && cyc > m_acc[k]) begin
                    chk("dp_price", k, o_dpp[k], m_p[k]);
                    chk("dp_num", k, o_dpn[k], m_n[k]);
                end
                for (int l = 0; l < 2; l++) begin
                    chk("done", k, o_done[k][l], ed[l]);
                    chk("total", k, o_total[k][l], m_tot[k][l]);
                    chk("ovf", k, o_ovf[k][l], m_ovf[k][l]);
                    if (o_done[k][l]) done_cyc[k][l] = cyc;
                end

                if (er[0] || er[1]) begin
                    ml         = er[1] ? 1 : 0;
                    m_infl[k]  = 1'b1;
                    m_acc[k]   = cyc;
                    m_lane[k]  = ml;
                    m_p[k]     = int'(b_price[k][ml]);
                    m_n[k]     = int'(b_num[k][ml]);
                    m_lastf[k] = b_last[k][ml];
                    m_rr[k]    = ml;
                    grant_q[k].push_back(ml);
                    acc_q[k].push_back(cyc);
                    acc_cnt[k][ml]++;
                    last_acc[k][ml] = cyc;
                    if (m_fresh[k][ml]) begin
                        m_tot[k][ml]   = 0;
                        m_ovf[k][ml]   = 1'b0;
                        m_fresh[k][ml] = 1'b0;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one item and holds it until accepted (bounded wait).
    task automatic send(input int k, input int lane, input int p, input int n,
                        input bit last);
        bit got;
        got = 1'b0;
        b_valid[k][lane] = 1'b1;
        b_price[k][lane] = 4'(p);
        b_num[k][lane]   = 4'(n);
        b_last[k][lane]  = last;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (o_ready[k][lane]) got = 1'b1;
        end
        @(posedge clk);
        #1;
        b_valid[k][lane] = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL send_timeout inst%0d lane%0d: got no ready, expected ready within 60 cycles", k, lane);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 2; l++) begin
                b_valid[k][l]  = 1'b0;
                b_price[k][l]  = 4'd0;
                b_num[k][l]    = 4'd0;
                b_last[k][l]   = 1'b0;
                acc_cnt[k][l]  = 0;
                done_cyc[k][l] = -1;
                last_acc[k][l] = -1;
            end
        end
        rst = 1'b1;
        #3 rst = 1'b0;
        tick(3);
        chk("lit_rst_busy", 0, o_busy[0], 0);
        chk("lit_rst_total0", 0, o_total[0][0], 0);
        chk("lit_rst_start", 3, o_start[3], 0);
        rst = 1'b1;
        tick(2);

        // LAT=1 single item, lane 0: 2 x 10
        send(0, 0, 2, 10, 1);
        tick(3);
        chk("lit_t1_total0", 0, o_total[0][0], 20);
        chk("lit_t1_done_lat", 0, done_cyc[0][0] - last_acc[0][0], 3);

        // LAT=1 two-item transaction on lane 1, then restart
        send(0, 1, 9, 2, 0);
        tick(3);
        chk("lit_t2_total1_a", 0, o_total[0][1], 18);
        chk("lit_t2_no_done", 0, done_cyc[0][1], -1);
        send(0, 1, 3, 4, 1);
        tick(3);
        chk("lit_t2_total1_b", 0, o_total[0][1], 30);
        tick(5);
        chk("lit_t2_hold", 0, o_total[0][1], 30);
        send(0, 1, 1, 1, 1);
        tick(3);
        chk("lit_t2_restart", 0, o_total[0][1], 1);
        chk("lit_t2_other_lane", 0, o_total[0][0], 20);

        // saturation: 19 items of 15 x 15 on lane 0
        for (int i = 0; i < 18; i++) begin
            send(0, 0, 15, 15, 0);
        end
        tick(3);
        chk("lit_t4_total_18", 0, o_total[0][0], 4050);
        chk("lit_t4_ovf_18", 0, o_ovf[0][0], 0);
        send(0, 0, 15, 15, 1);
        tick(3);
        chk("lit_t4_total_19", 0, o_total[0][0], 4095);
        chk("lit_t4_ovf_19", 0, o_ovf[0][0], 1);
        tick(4);
        chk("lit_t4_ovf_sticky", 0, o_ovf[0][0], 1);
        send(0, 0, 1, 1, 1);
        chk("lit_t4_ovf_clear", 0, o_ovf[0][0], 0);
        tick(3);
        chk("lit_t4_total_new", 0, o_total[0][0], 1);

        // LAT=2 both lanes continuously valid: strict alternation
        fork
            begin
                send(1, 0, 1, 2, 0);
                send(1, 0, 3, 3, 1);
            end
            begin
                send(1, 1, 2, 2, 0);
                send(1, 1, 5, 1, 1);
            end
        join
        tick(5);
        chk("lit_t3_grants", 1, grant_q[1].size(), 4);
        if (grant_q[1].size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("lit_t3_grant_order", 1, grant_q[1][i], i % 2);
                if (i > 0) chk("lit_t3_spacing", 1, acc_q[1][i] - acc_q[1][i-1], 4);
            end
        end
        chk("lit_t3_total0", 1, o_total[1][0], 11);
        chk("lit_t3_total1", 1, o_total[1][1], 9);

        // LAT=3 lane 0 withdraws its request while busy
        fork
            begin
                send(2, 1, 2, 3, 1);
                send(2, 1, 4, 4, 1);
            end
            begin
                tick(2);
                b_valid[2][0] = 1'b1;
                b_price[2][0] = 4'd7;
                b_num[2][0]   = 4'd7;
                b_last[2][0]  = 1'b1;
                tick(2);
                b_valid[2][0] = 1'b0;
            end
        join
        tick(6);
        chk("lit_t6_lane0_accepts", 2, acc_cnt[2][0], 0);
        chk("lit_t6_total0", 2, o_total[2][0], 0);
        chk("lit_t6_total1", 2, o_total[2][1], 16);

        // LAT=4 reset during WAIT, then tie after release
        send(3, 0, 3, 3, 1);
        tick(1);
        rst = 1'b0;
        #1;
        chk("lit_t5_busy", 3, o_busy[3], 0);
        chk("lit_t5_start", 3, o_start[3], 0);
        chk("lit_t5_total_k0", 0, o_total[0][0], 0);
        chk("lit_t5_total_k3", 3, o_total[3][0], 0);
        tick(2);
        rst = 1'b1;
        fork
            send(3, 0, 1, 2, 1);
            send(3, 1, 2, 2, 1);
        join
        tick(8);
        chk("lit_t5_no_done", 3, done_cyc[3][0] > last_acc[3][0] - 8 ? 1 : 0, 1);
        if (grant_q[3].size() >= 2) begin
            chk("lit_t5_tie_first", 3, grant_q[3][grant_q[3].size()-2], 0);
        end else begin
            chk("lit_t5_grant_count", 3, grant_q[3].size(), 3);
        end
        chk("lit_t5_total0", 3, o_total[3][0], 2);
        chk("lit_t5_total1", 3, o_total[3][1], 4);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
